// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus access path: state codes,
// default phase timing and operation encoding.
package rtc_bus_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_A_SETUP  = 4'd1;
    localparam logic [3:0] ST_A_STROBE = 4'd2;
    localparam logic [3:0] ST_A_HOLD   = 4'd3;
    localparam logic [3:0] ST_GAP      = 4'd4;
    localparam logic [3:0] ST_D_SETUP  = 4'd5;
    localparam logic [3:0] ST_D_STROBE = 4'd6;
    localparam logic [3:0] ST_D_HOLD   = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_A_SETUP  = ST_A_SETUP,
        S_A_STROBE = ST_A_STROBE,
        S_A_HOLD   = ST_A_HOLD,
        S_GAP      = ST_GAP,
        S_D_SETUP  = ST_D_SETUP,
        S_D_STROBE = ST_D_STROBE,
        S_D_HOLD   = ST_D_HOLD,
        S_DONE     = ST_DONE
    } state_e;

    localparam int DEF_T_SETUP  = 2;
    localparam int DEF_T_STROBE = 10;
    localparam int DEF_T_HOLD   = 2;
    localparam int DEF_T_GAP    = 10;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rtc_bus_driver_if.sv
// Request/response handshake plus RTC pin-side signals of the bus driver.
// The slave modport is the driver itself; master is the surrounding logic/pads.
interface rtc_bus_driver_if;
    logic       req_wr;
    logic       req_rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       rtc_cs_n;
    logic       rtc_ad_n;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output req_wr, req_rd, addr, wdata, ad_in,
        input  rdata, busy, done, rtc_cs_n, rtc_ad_n, rtc_rd_n, rtc_wr_n, ad_out, ad_oe
    );

    modport slave (
        input  req_wr, req_rd, addr, wdata, ad_in,
        output rdata, busy, done, rtc_cs_n, rtc_ad_n, rtc_rd_n, rtc_wr_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_driver_phase_timer.sv
// Down-counter shared by all timed FSM states: a load of N makes expire
// assert on the N-th cycle after the load, so the owning state lasts N cycles.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_val == '0) ? '0 : load_val - W'(1);
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/rtc_bus_driver.sv
// Two-phase (address, then data) access engine for the RTC multiplexed AD bus.
// Every pin is a flop whose next value is decoded from the next FSM state.
module rtc_bus_driver
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int T_GAP    = DEF_T_GAP
) (
    input  logic             clk,
    input  logic             reset,
    rtc_bus_driver_if.slave  bus
);

    localparam int T_MAX = max4(T_SETUP, T_STROBE, T_HOLD, T_GAP);
    localparam int TW    = $clog2(T_MAX) + 1;

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;

    logic       cs_n_q, cs_n_d;
    logic       ad_n_q, ad_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Next-state and request capture; requests only count while idle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_wr || bus.req_rd) begin
                    state_d = S_A_SETUP;
                    op_d    = bus.req_wr ? OP_WR : OP_RD;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                end
            end
            S_A_SETUP:  if (tmr_expire) state_d = S_A_STROBE;
            S_A_STROBE: if (tmr_expire) state_d = S_A_HOLD;
            S_A_HOLD:   if (tmr_expire) state_d = S_GAP;
            S_GAP:      if (tmr_expire) state_d = S_D_SETUP;
            S_D_SETUP:  if (tmr_expire) state_d = S_D_STROBE;
            S_D_STROBE: if (tmr_expire) state_d = S_D_HOLD;
            S_D_HOLD:   if (tmr_expire) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Reload the timer on every entry into a timed state.
    always_comb begin
        tmr_val  = '0;
        tmr_load = 1'b0;
        case (state_d)
            S_A_SETUP, S_D_SETUP:   tmr_val = TW'(T_SETUP);
            S_A_STROBE, S_D_STROBE: tmr_val = TW'(T_STROBE);
            S_A_HOLD, S_D_HOLD:     tmr_val = TW'(T_HOLD);
            S_GAP:                  tmr_val = TW'(T_GAP);
            default:                tmr_val = '0;
        endcase
        if ((state_d != state_q) && (tmr_val != '0)) begin
            tmr_load = 1'b1;
        end
    end

    // Pin decode from the state being entered, so pins line up with state_q.
    always_comb begin
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rdata_d  = rdata_q;
        case (state_d)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                ad_n_d   = (state_d != S_A_STROBE);
            end
            S_GAP: begin
                cs_n_d = 1'b0;
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                cs_n_d = 1'b0;
                if (op_d == OP_WR) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                    wr_n_d   = (state_d != S_D_STROBE);
                end else begin
                    rd_n_d   = (state_d != S_D_STROBE);
                end
            end
            default: ;
        endcase
        // Sample the pad while rd_n is still low, on the final strobe cycle.
        if ((state_q == S_D_STROBE) && tmr_expire && (op_q == OP_RD)) begin
            rdata_d = bus.ad_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cs_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cs_n_q   <= cs_n_d;
            ad_n_q   <= ad_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rtc_cs_n = cs_n_q;
    assign bus.rtc_ad_n = ad_n_q;
    assign bus.rtc_rd_n = rd_n_q;
    assign bus.rtc_wr_n = wr_n_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_out   = ad_out_q;

endmodule
